layer_cfg_buffer: RTL and testbench
===================================

// Module: layer_cfg_buffer
// PURPOSE
//  Sits between the PS configuration path and the main controller, on the ddr_user_clk side.
//  Accepts a task header beat plus 128-bit configuration beats.
//  Packs every four beats into one 512-bit layer descriptor and stores the descriptors in a local buffer.
//  The controller then pulls the descriptors one layer at a time, with an explicit last-layer flag.
// PARAMETERS
//  CFG_W    128  input beat width (fixed; LAYER_W = 4*CFG_W)
//  LAYER_W  512  layer descriptor width
//  DEPTH    32   max layers per task
//  AW       5    layer address width, log2(DEPTH)
// PORTS
//  ddr_user_clk       in   1        sole clock
//  ddr_user_rst       in   1        asynchronous, active-high reset
//  I_cfg_data         in   CFG_W    header or configuration beat
//  I_cfg_data_valid   in   1        beat qualifier, one beat per cycle
//  I_task_clear       in   1        abort/restart; return to IDLE
//  I_layer_req        in   1        pulse: request next stored descriptor
//  O_layer_cfg_value  out  LAYER_W  descriptor read out
//  O_layer_cfg_valid  out  1        1-cycle qualifier for O_layer_cfg_value
//  O_last_layer       out  1        high with valid when descriptor is layer num_layers-1
//  O_load_done        out  1        1-cycle pulse when the final descriptor is written
//  O_task_done        out  1        level; last descriptor issued, until clear
//  O_hdr_err          out  1        1-cycle pulse; header rejected
//  O_ovf_err          out  1        sticky; beat arrived outside IDLE/LOAD
//  O_state            out  2        current FSM state (debug)
// BEHAVIOUR
//  Reset: all outputs 0; O_state=IDLE; counters 0; buffer contents not cleared (don't-care).
//  States: IDLE=0, LOAD=1, READY=2, DONE=3.
//  IDLE:
//   - Valid beat is the header; num_layers = I_cfg_data[5:0].
//   - num_layers 1..DEPTH -> latch it, go to LOAD.
//   - num_layers 0 or >DEPTH -> O_hdr_err pulse next cycle, stay IDLE.
//  LOAD:
//   - Beats land in a 2-bit beat counter and a 3x128 shadow register; first beat = bits[127:0].
//   - 4th beat writes {b3,b2,b1,b0} to mem[wr_layer]; beat_cnt wraps to 0; wr_layer increments.
//   - Write of wr_layer == num_layers-1: O_load_done pulses the next cycle, FSM goes to READY, rd_layer=0.
//  READY:
//   - I_layer_req at cycle n -> O_layer_cfg_value = mem[rd_layer] and O_layer_cfg_valid=1 at n+1 (1-cycle latency, registered).
//   - rd_layer increments. O_last_layer = (rd_layer == num_layers-1), registered with valid.
//   - Issuing the last descriptor moves the FSM to DONE; O_task_done=1 from the same cycle valid rises.
//   - Requests on back-to-back cycles are legal; each yields one descriptor.
//  DONE: I_layer_req ignored (no valid). A new task requires I_task_clear.
//  I_layer_req outside READY: ignored, no output.
//  I_cfg_data_valid in READY/DONE: beat dropped, O_ovf_err set (sticky).
//  I_task_clear (any state):
//   - Next cycle IDLE; counters, O_task_done and O_ovf_err cleared.
//   - Clears the valid/last/load_done pulses that would otherwise occur the next cycle.
//   - Clear wins over a simultaneous beat or req.
//  Async reset mid-LOAD or mid-READY: immediate return to IDLE; partially packed layer discarded.
//  O_layer_cfg_value holds its last value when valid=0.
// TESTING
//  1. Header 3, then 12 beats 0x..01..0x..0C
//     -> O_load_done once after beat 12.
//     -> 3 reqs give layers {4,3,2,1},{8..5},{C..9}; O_last_layer only on 3rd; O_task_done=1.
//  2. Header 0, then header 33
//     -> two O_hdr_err pulses, O_state stays IDLE, no load_done.
//  3. Header 1 + 4 beats + 1 extra beat
//     -> O_ovf_err=1 sticky; req returns the first 4 beats packed; extra beat not stored.
//  4. Header 32 + 128 beats, 32 back-to-back reqs
//     -> 32 consecutive valid cycles; last on 32nd; a 33rd req gives no valid.
//  5. I_task_clear together with 2nd beat of layer 0, then header 1 + 4 beats
//     -> IDLE, then normal load; the pre-clear beat is absent from the descriptor.
//  6. Assert ddr_user_rst during READY after 1 of 2 layers read
//     -> all outputs 0 asynchronously, O_state=0; req after release gives no valid.

Source files
------------

// File: rtl/layer_cfg_buffer.sv
// Task configuration buffer: accepts a header beat plus 128-bit configuration beats,
// packs them four at a time into layer descriptors and hands them to the controller on request.
module layer_cfg_buffer #(
   parameter int CFG_W   = 128,
   parameter int LAYER_W = 512,
   parameter int DEPTH   = 32,
   parameter int AW      = 5
) (
   input  logic               ddr_user_clk,
   input  logic               ddr_user_rst,
   input  logic [CFG_W-1:0]   I_cfg_data,
   input  logic               I_cfg_data_valid,
   input  logic               I_task_clear,
   input  logic               I_layer_req,
   output logic [LAYER_W-1:0] O_layer_cfg_value,
   output logic               O_layer_cfg_valid,
   output logic               O_last_layer,
   output logic               O_load_done,
   output logic               O_task_done,
   output logic               O_hdr_err,
   output logic               O_ovf_err,
   output logic [1:0]         O_state
);

   localparam int NW = AW + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [NW-1:0]         num_layers_q, num_layers_d;
   logic [1:0]            beat_cnt_q, beat_cnt_d;
   logic [AW-1:0]         wr_layer_q, wr_layer_d;
   logic [AW-1:0]         rd_layer_q, rd_layer_d;
   logic [2:0][CFG_W-1:0] shadow_q, shadow_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic                  load_done_q, load_done_d;
   logic                  hdr_err_q, hdr_err_d;
   logic                  task_done_q, task_done_d;
   logic                  ovf_q, ovf_d;
   logic [LAYER_W-1:0]    value_q;

   logic                  mem_we;
   logic                  mem_re;
   logic [NW-1:0]         hdr_layers;
   logic [NW-1:0]         last_idx;
   logic                  hdr_ok;
   logic                  wr_is_last;
   logic                  rd_is_last;

   logic [LAYER_W-1:0]    mem [DEPTH];

   assign hdr_layers = I_cfg_data[NW-1:0];
   assign hdr_ok     = (hdr_layers != '0) && (hdr_layers <= NW'(DEPTH));
   assign last_idx   = num_layers_q - 1'b1;
   assign wr_is_last = ({1'b0, wr_layer_q} == last_idx);
   assign rd_is_last = ({1'b0, rd_layer_q} == last_idx);

   always_comb begin
      state_d      = state_q;
      num_layers_d = num_layers_q;
      beat_cnt_d   = beat_cnt_q;
      wr_layer_d   = wr_layer_q;
      rd_layer_d   = rd_layer_q;
      shadow_d     = shadow_q;
      valid_d      = 1'b0;
      last_d       = 1'b0;
      load_done_d  = 1'b0;
      hdr_err_d    = 1'b0;
      task_done_d  = task_done_q;
      ovf_d        = ovf_q;
      mem_we       = 1'b0;
      mem_re       = 1'b0;

      if (I_task_clear) begin
         // Clear overrides any beat or request presented in the same cycle.
         state_d     = ST_IDLE;
         beat_cnt_d  = '0;
         wr_layer_d  = '0;
         rd_layer_d  = '0;
         task_done_d = 1'b0;
         ovf_d       = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (I_cfg_data_valid) begin
                  if (hdr_ok) begin
                     num_layers_d = hdr_layers;
                     beat_cnt_d   = '0;
                     wr_layer_d   = '0;
                     rd_layer_d   = '0;
                     state_d      = ST_LOAD;
                  end else begin
                     hdr_err_d = 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (I_cfg_data_valid) begin
                  if (beat_cnt_q == 2'd3) begin
                     // Fourth beat goes straight to memory together with the three shadowed beats.
                     mem_we     = 1'b1;
                     beat_cnt_d = '0;
                     wr_layer_d = wr_layer_q + 1'b1;
                     if (wr_is_last) begin
                        load_done_d = 1'b1;
                        rd_layer_d  = '0;
                        state_d     = ST_READY;
                     end
                  end else begin
                     shadow_d   = {I_cfg_data, shadow_q[2:1]};
                     beat_cnt_d = beat_cnt_q + 1'b1;
                  end
               end
            end
            ST_READY: begin
               if (I_cfg_data_valid) begin
                  ovf_d = 1'b1;
               end
               if (I_layer_req) begin
                  mem_re     = 1'b1;
                  valid_d    = 1'b1;
                  last_d     = rd_is_last;
                  rd_layer_d = rd_layer_q + 1'b1;
                  if (rd_is_last) begin
                     task_done_d = 1'b1;
                     state_d     = ST_DONE;
                  end
               end
            end
            default: begin
               if (I_cfg_data_valid) begin
                  ovf_d = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge ddr_user_clk or posedge ddr_user_rst) begin
      if (ddr_user_rst) begin
         state_q      <= ST_IDLE;
         num_layers_q <= '0;
         beat_cnt_q   <= '0;
         wr_layer_q   <= '0;
         rd_layer_q   <= '0;
         shadow_q     <= '0;
         valid_q      <= 1'b0;
         last_q       <= 1'b0;
         load_done_q  <= 1'b0;
         hdr_err_q    <= 1'b0;
         task_done_q  <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         num_layers_q <= num_layers_d;
         beat_cnt_q   <= beat_cnt_d;
         wr_layer_q   <= wr_layer_d;
         rd_layer_q   <= rd_layer_d;
         shadow_q     <= shadow_d;
         valid_q      <= valid_d;
         last_q       <= last_d;
         load_done_q  <= load_done_d;
         hdr_err_q    <= hdr_err_d;
         task_done_q  <= task_done_d;
         ovf_q        <= ovf_d;
      end
   end

   // Descriptor storage has no reset so it can map onto block RAM.
   always_ff @(posedge ddr_user_clk) begin
      if (mem_we) begin
         mem[wr_layer_q] <= {I_cfg_data, shadow_q};
      end
   end

   // Registered read port; the output holds its last descriptor between requests.
   always_ff @(posedge ddr_user_clk or posedge ddr_user_rst) begin
      if (ddr_user_rst) begin
         value_q <= '0;
      end else if (mem_re) begin
         value_q <= mem[rd_layer_q];
      end
   end

   assign O_layer_cfg_value = value_q;
   assign O_layer_cfg_valid = valid_q;
   assign O_last_layer      = last_q;
   assign O_load_done       = load_done_q;
   assign O_task_done       = task_done_q;
   assign O_hdr_err         = hdr_err_q;
   assign O_ovf_err         = ovf_q;
   assign O_state           = state_q;

endmodule

// File: tb/tb_layer_cfg_buffer.sv
// Bench for layer_cfg_buffer: directed task sequences, a queue-based transaction model
// compared every cycle, and literal expectations for key descriptors and pulse counts.
module tb_layer_cfg_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] I_cfg_data;
   logic         I_cfg_data_valid;
   logic         I_task_clear;
   logic         I_layer_req;
   logic [511:0] O_layer_cfg_value;
   logic         O_layer_cfg_valid;
   logic         O_last_layer;
   logic         O_load_done;
   logic         O_task_done;
   logic         O_hdr_err;
   logic         O_ovf_err;
   logic [1:0]   O_state;

   always #5 clk = ~clk;

   layer_cfg_buffer dut (
      .ddr_user_clk      (clk),
      .ddr_user_rst      (rst),
      .I_cfg_data        (I_cfg_data),
      .I_cfg_data_valid  (I_cfg_data_valid),
      .I_task_clear      (I_task_clear),
      .I_layer_req       (I_layer_req),
      .O_layer_cfg_value (O_layer_cfg_value),
      .O_layer_cfg_valid (O_layer_cfg_valid),
      .O_last_layer      (O_last_layer),
      .O_load_done       (O_load_done),
      .O_task_done       (O_task_done),
      .O_hdr_err         (O_hdr_err),
      .O_ovf_err         (O_ovf_err),
      .O_state           (O_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Transaction-level model: accepted header, received beats, descriptors read so far.
   bit           m_active = 1'b0;
   int           m_n      = 0;
   int           m_read   = 0;
   logic [127:0] m_beats[$];

   logic         exp_valid = 0, exp_last = 0, exp_load_done = 0, exp_hdr_err = 0;
   logic         exp_task_done = 0, exp_ovf = 0;
   logic [511:0] exp_value = '0;
   logic [1:0]   exp_state = '0;
   logic         nxt_valid, nxt_last, nxt_load_done, nxt_hdr_err, nxt_task_done, nxt_ovf;
   logic [511:0] nxt_value;
   logic [1:0]   nxt_state;

   bit chk_en = 1'b0;
   int seen_valid = 0, seen_last = 0, seen_load_done = 0, seen_hdr_err = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int phase();
      if (!m_active) return 0;
      if (m_beats.size() < 4 * m_n) return 1;
      if (m_read < m_n) return 2;
      return 3;
   endfunction

   task automatic model_step(input logic v, input logic [127:0] d, input logic clr, input logic req);
      int ph;
      int h;
      nxt_valid     = 1'b0;
      nxt_last      = 1'b0;
      nxt_load_done = 1'b0;
      nxt_hdr_err   = 1'b0;
      nxt_value     = exp_value;
      nxt_task_done = exp_task_done;
      nxt_ovf       = exp_ovf;
      if (clr) begin
         m_active = 1'b0;
         m_read   = 0;
         m_beats.delete();
         nxt_task_done = 1'b0;
         nxt_ovf       = 1'b0;
      end else begin
         ph = phase();
         if (v && ph == 0) begin
            h = int'(d[5:0]);
            if (h >= 1 && h <= 32) begin
               m_active = 1'b1;
               m_n      = h;
               m_read   = 0;
               m_beats.delete();
            end else begin
               nxt_hdr_err = 1'b1;
            end
         end else if (v && ph == 1) begin
            m_beats.push_back(d);
            if (m_beats.size() == 4 * m_n) nxt_load_done = 1'b1;
         end else if (v) begin
            nxt_ovf = 1'b1;
         end
         if (req && ph == 2) begin
            nxt_value = {m_beats[4*m_read+3], m_beats[4*m_read+2],
                         m_beats[4*m_read+1], m_beats[4*m_read]};
            nxt_valid = 1'b1;
            nxt_last  = (m_read == m_n - 1);
            m_read++;
            if (m_read == m_n) nxt_task_done = 1'b1;
         end
      end
      nxt_state = 2'(phase());
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_read   = 0;
      m_beats.delete();
      exp_valid = 0; exp_last = 0; exp_load_done = 0; exp_hdr_err = 0;
      exp_task_done = 0; exp_ovf = 0; exp_value = '0; exp_state = '0;
   endtask

   task automatic cyc(input logic v, input logic [127:0] d, input logic clr, input logic req);
      I_cfg_data_valid = v;
      I_cfg_data       = d;
      I_task_clear     = clr;
      I_layer_req      = req;
      model_step(v, d, clr, req);
      @(posedge clk);
      #1;
      exp_valid = nxt_valid; exp_last = nxt_last; exp_load_done = nxt_load_done;
      exp_hdr_err = nxt_hdr_err; exp_task_done = nxt_task_done; exp_ovf = nxt_ovf;
      exp_value = nxt_value; exp_state = nxt_state;
      I_cfg_data_valid = 1'b0;
      I_task_clear     = 1'b0;
      I_layer_req      = 1'b0;
      $display("cyc v=%0b d=%0h clr=%0b req=%0b -> state=%0d valid=%0b last=%0b",
               v, d[31:0], clr, req, O_state, O_layer_cfg_valid, O_last_layer);
   endtask

   function automatic logic [127:0] bt(input int i);
      return {32'hC0DE0000 | 32'(i), ~32'(i), 32'(i * 7), 32'(i)};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("valid",     512'(O_layer_cfg_valid), 512'(exp_valid));
         check("last",      512'(O_last_layer),      512'(exp_last));
         check("load_done", 512'(O_load_done),       512'(exp_load_done));
         check("hdr_err",   512'(O_hdr_err),         512'(exp_hdr_err));
         check("task_done", 512'(O_task_done),       512'(exp_task_done));
         check("ovf_err",   512'(O_ovf_err),         512'(exp_ovf));
         check("state",     512'(O_state),           512'(exp_state));
         check("value",     O_layer_cfg_value,       exp_value);
         if (O_layer_cfg_valid === 1'b1) seen_valid++;
         if (O_last_layer === 1'b1)      seen_last++;
         if (O_load_done === 1'b1)       seen_load_done++;
         if (O_hdr_err === 1'b1)         seen_hdr_err++;
      end
   end

   initial begin
      logic [511:0] lit;
      rst = 1'b1;
      I_cfg_data = '0; I_cfg_data_valid = 0; I_task_clear = 0; I_layer_req = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {O_layer_cfg_value, O_layer_cfg_valid, O_last_layer, O_load_done,
                              O_task_done, O_hdr_err, O_ovf_err, O_state}, '0);
      rst = 1'b0;
      chk_en = 1'b1;

      // 1: three layers from beats 1..12
      seen_load_done = 0; seen_last = 0;
      cyc(1, 128'd3, 0, 0);
      for (int i = 1; i <= 12; i++) cyc(1, 128'(i), 0, 0);
      cyc(0, '0, 0, 0);
      cyc(0, '0, 0, 1);
      lit = {128'd4, 128'd3, 128'd2, 128'd1};
      check("t1_layer0", O_layer_cfg_value, lit);
      cyc(0, '0, 0, 1);
      lit = {128'd8, 128'd7, 128'd6, 128'd5};
      check("t1_layer1", O_layer_cfg_value, lit);
      cyc(0, '0, 0, 1);
      lit = {128'd12, 128'd11, 128'd10, 128'd9};
      check("t1_layer2", O_layer_cfg_value, lit);
      check("t1_last", 512'(O_last_layer), 512'(1));
      check("t1_task_done", 512'(O_task_done), 512'(1));
      cyc(0, '0, 0, 1);
      check("t1_load_done_count", 512'(seen_load_done), 512'(1));
      check("t1_last_count", 512'(seen_last), 512'(1));

      // 2: out-of-range headers
      cyc(0, '0, 1, 0);
      seen_hdr_err = 0; seen_load_done = 0;
      cyc(1, 128'd0, 0, 0);
      cyc(1, 128'd33, 0, 0);
      cyc(0, '0, 0, 0);
      check("t2_hdr_err_count", 512'(seen_hdr_err), 512'(2));
      check("t2_state", 512'(O_state), 512'(0));
      check("t2_no_load_done", 512'(seen_load_done), 512'(0));

      // 3: one layer plus an overflow beat
      cyc(1, 128'd1, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 128'(32'hA0 + i), 0, 0);
      cyc(0, '0, 0, 0);
      check("t3_ovf", 512'(O_ovf_err), 512'(1));
      cyc(0, '0, 0, 1);
      lit = {128'hA3, 128'hA2, 128'hA1, 128'hA0};
      check("t3_layer0", O_layer_cfg_value, lit);
      check("t3_ovf_sticky", 512'(O_ovf_err), 512'(1));

      // 4: full depth, back-to-back requests
      cyc(0, '0, 1, 0);
      cyc(1, 128'd32, 0, 0);
      for (int i = 0; i < 128; i++) cyc(1, bt(i), 0, 0);
      seen_valid = 0; seen_last = 0;
      for (int i = 0; i < 33; i++) cyc(0, '0, 0, 1);
      cyc(0, '0, 0, 0);
      check("t4_valid_count", 512'(seen_valid), 512'(32));
      check("t4_last_count", 512'(seen_last), 512'(1));

      // 5: clear collides with the second beat of layer 0
      cyc(0, '0, 1, 0);
      cyc(1, 128'd1, 0, 0);
      cyc(1, 128'hBAD0, 0, 0);
      cyc(1, 128'hBAD1, 1, 0);
      check("t5_state_idle", 512'(O_state), 512'(0));
      cyc(1, 128'd1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 128'(32'h50 + i), 0, 0);
      cyc(0, '0, 0, 1);
      lit = {128'h53, 128'h52, 128'h51, 128'h50};
      check("t5_layer0", O_layer_cfg_value, lit);

      // 6: asynchronous reset after one of two layers read
      cyc(0, '0, 1, 0);
      cyc(1, 128'd2, 0, 0);
      for (int i = 0; i < 8; i++) cyc(1, 128'(32'h70 + i), 0, 0);
      cyc(0, '0, 0, 1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_outputs", {O_layer_cfg_value, O_layer_cfg_valid, O_last_layer, O_load_done,
                                 O_task_done, O_hdr_err, O_ovf_err, O_state}, '0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(0, '0, 0, 1);
      check("t6_req_after_reset", 512'(O_layer_cfg_valid), 512'(0));
      cyc(0, '0, 0, 0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
